// File: rtl/fht_loader.sv
// Input stage of the FHT core: streams one frame of ADC samples into the core's four-bank RAM, then starts the core.
// Define FHT_LOADER_DREV_EN for radix-4 digit-reversed addressing; the default build loads in natural order.
module fht_loader #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 8
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iARM,
  input  logic                    iVALID,
  input  logic signed [D_BIT-2:0] iSAMPLE,
  output logic                    oREADY,
  output logic signed [D_BIT-2:0] oDATA,
  output logic [A_BIT-1:0]        oADDR_WR_0,
  output logic [A_BIT-1:0]        oADDR_WR_1,
  output logic [A_BIT-1:0]        oADDR_WR_2,
  output logic [A_BIT-1:0]        oADDR_WR_3,
  output logic                    oWE_0,
  output logic                    oWE_1,
  output logic                    oWE_2,
  output logic                    oWE_3,
  output logic                    oSTART,
  input  logic                    iRDY,
  output logic                    oDONE,
  output logic                    oOVF,
  output logic                    oBUSY
);

  localparam int N_BIT = A_BIT + 2;
  localparam int NDIG  = N_BIT / 2;

  if ((A_BIT % 2) != 0) begin : g_bad_abit
    $error("fht_loader: A_BIT must be even so the frame length is a power of 4");
  end

  typedef enum logic [2:0] {IDLE, LOAD, STRT, WAIT1, WAIT2, DONE} state_t;

  state_t                  state_q, state_d;
  logic [N_BIT-1:0]        n_q, n_d;
  logic [1:0]              wcnt_q, wcnt_d;
  logic                    ovf_q, ovf_d;
  logic [3:0]              we_q;
  logic [A_BIT-1:0]        addr_q;
  logic signed [D_BIT-2:0] data_q;
  logic                    start_q;
  logic                    accept;
  logic [N_BIT-1:0]        r;

`ifdef FHT_LOADER_DREV_EN
  function automatic logic [N_BIT-1:0] digitReverse(input logic [N_BIT-1:0] v);
    logic [N_BIT-1:0] res;
    res = '0;
    for (int i = 0; i < NDIG; i++) begin
      res[2*(NDIG-1-i) +: 2] = v[2*i +: 2];
    end
    return res;
  endfunction

  assign r = digitReverse(n_q);
`else
  assign r = n_q;
`endif

  assign accept = (state_q == LOAD) && iVALID;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    oREADY  = 1'b0;
    oDONE   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iARM) begin
          state_d = LOAD;
          n_d     = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        oREADY = 1'b1;
        if (iVALID) begin
          n_d = n_q + 1'b1;
          if (&n_q) state_d = STRT;
        end
      end
      STRT: begin
        wcnt_d  = '0;
        state_d = WAIT1;
      end
      // A core that never visibly drops ready is given four cycles before we move on.
      WAIT1: begin
        if (!iRDY || (wcnt_q == 2'd3)) state_d = WAIT2;
        else wcnt_d = wcnt_q + 2'd1;
      end
      WAIT2: begin
        if (iRDY) state_d = DONE;
      end
      DONE: begin
        oDONE   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (iVALID && (state_q != LOAD)) ovf_d = 1'b1;
  end

  // oSTART is registered from STRT so it lands one cycle after the final write enable.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      we_q    <= accept ? (4'b0001 << r[N_BIT-1 -: 2]) : 4'b0000;
      start_q <= (state_q == STRT);
      if (accept) begin
        addr_q <= r[A_BIT-1:0];
        data_q <= iSAMPLE;
      end
    end
  end

  assign oDATA      = data_q;
  assign oADDR_WR_0 = addr_q;
  assign oADDR_WR_1 = addr_q;
  assign oADDR_WR_2 = addr_q;
  assign oADDR_WR_3 = addr_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oSTART     = start_q;
  assign oOVF       = ovf_q;
  assign oBUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_fht_loader.sv
// Self-checking bench for fht_loader: vector table for the idle/arm/overflow corner, then full frames checked
// against an arithmetic model of the write order, start pulse and done timing.
module tb_fht_loader;
  localparam int D_BIT = 17;
  localparam int A_BIT = 8;
  localparam int N     = 4 * (1 << A_BIT);
  localparam int BANK  = N / 4;

  logic                    iCLK = 1'b0;
  logic                    iRESET, iARM, iVALID, iRDY;
  logic signed [D_BIT-2:0] iSAMPLE;
  logic                    oREADY, oSTART, oDONE, oOVF, oBUSY;
  logic signed [D_BIT-2:0] oDATA;
  logic [A_BIT-1:0]        oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic                    oWE_0, oWE_1, oWE_2, oWE_3;

  fht_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iARM(iARM), .iVALID(iVALID), .iSAMPLE(iSAMPLE),
    .oREADY(oREADY), .oDATA(oDATA),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
    .oSTART(oSTART), .iRDY(iRDY), .oDONE(oDONE), .oOVF(oOVF), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {int cyc; int bank; int addr; int data; int weCnt; bit addrSame;} wr_t;
  typedef struct {int cyc; int bank; int addr; int data;} exp_t;

  wr_t  wrQ[$];
  int   startQ[$];
  int   doneQ[$];
  exp_t expQ[$];

  int checks = 0;
  int failures = 0;
  int modelN, lastAcc, wrBase, stBase, dnBase;

  // Passive observer of everything the loader writes or pulses, stamped with the cycle number.
  always @(negedge iCLK) begin
    wr_t w;
    w.weCnt = int'(oWE_0) + int'(oWE_1) + int'(oWE_2) + int'(oWE_3);
    if (w.weCnt > 0) begin
      w.cyc      = cyc;
      w.bank     = oWE_3 ? 3 : oWE_2 ? 2 : oWE_1 ? 1 : 0;
      w.addr     = int'(oADDR_WR_0);
      w.data     = int'(oDATA);
      w.addrSame = (oADDR_WR_0 == oADDR_WR_1) && (oADDR_WR_0 == oADDR_WR_2) && (oADDR_WR_0 == oADDR_WR_3);
      wrQ.push_back(w);
    end
    if (oSTART) startQ.push_back(cyc);
    if (oDONE) doneQ.push_back(cyc);
  end

  // Position in RAM of sample n: its base-4 digits read backwards, or n itself for natural order.
  function automatic int refR(input int n);
`ifdef FHT_LOADER_DREV_EN
    int d, res;
    d = n;
    res = 0;
    for (int i = 0; i < (A_BIT + 2) / 2; i++) begin
      res = res * 4 + d % 4;
      d = d / 4;
    end
    return res;
`else
    return n;
`endif
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic arm, input logic valid,
                               input logic signed [D_BIT-2:0] smp, input logic rdy);
    iRESET = rst; iARM = arm; iVALID = valid; iSAMPLE = smp; iRDY = rdy;
    @(posedge iCLK);
    #1;
  endtask

  task automatic acceptSample(input logic signed [D_BIT-2:0] smp, input logic arm, input logic rdy);
    exp_t e;
    int   r;
    r      = refR(modelN);
    e.cyc  = cyc + 1;
    e.bank = r / BANK;
    e.addr = r % BANK;
    e.data = int'(smp);
    expQ.push_back(e);
    lastAcc = cyc;
    modelN++;
    applyStimulus(1'b0, arm, 1'b1, smp, rdy);
  endtask

  task automatic beginFrame();
    expQ.delete();
    modelN = 0;
    wrBase = wrQ.size();
    stBase = startQ.size();
    dnBase = doneQ.size();
  endtask

  task automatic startFrame();
    beginFrame();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("armReady", int'(oREADY), 1);
    checkOutput("armOvfClear", int'(oOVF), 0);
  endtask

  task automatic loadFrame(input int count, input bit rnd);
    for (int i = 0; i < count; i++) begin
      if (rnd && $urandom_range(3) == 0)
        applyStimulus(1'b0, 1'($urandom_range(1)), 1'b0, 16'($urandom), 1'($urandom_range(1)));
      if (rnd) acceptSample(16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
      else acceptSample(16'(modelN), 1'b0, 1'b0);
    end
  endtask

  // Ready pattern seen from the start cycle: h cycles high, lo low, then high again.
  task automatic finishFrame(input int h, input int lo);
    int pat[$];
    int s, w2, done;
    s = lastAcc + 2;
    for (int i = 0; i < h; i++) pat.push_back(1);
    for (int i = 0; i < lo; i++) pat.push_back(0);
    for (int i = 0; i < 4; i++) pat.push_back(1);
    w2 = 4;
    for (int c = 0; c < 4; c++) if (pat[c] == 0) begin w2 = c + 1; break; end
    done = -1;
    for (int c = w2; c < pat.size(); c++) if (pat[c] == 1) begin done = s + c + 1; break; end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int c = 0; c < pat.size(); c++) begin
      applyStimulus(1'b0, (h <= 4 && lo >= 2 && c == h + 1), 1'b0, '0, 1'(pat[c]));
      if (cyc == done) begin
        checkOutput("doneHigh", int'(oDONE), 1);
        checkOutput("busyAtDone", int'(oBUSY), 1);
      end
      if (cyc == done + 1) begin
        checkOutput("busyFall", int'(oBUSY), 0);
        checkOutput("readyIdle", int'(oREADY), 0);
      end
    end
    checkOutput("startCount", startQ.size() - stBase, 1);
    checkOutput("startCycle", (startQ.size() > stBase) ? startQ[stBase] : -1, s);
    checkOutput("doneCount", doneQ.size() - dnBase, 1);
    checkOutput("doneCycle", (doneQ.size() > dnBase) ? doneQ[dnBase] : -1, done);
  endtask

  task automatic checkNamed(input int n, input int bank, input int addr);
    int idx;
    idx = wrBase + n;
    checkOutput($sformatf("bank[n=%0d]", n), (idx < wrQ.size()) ? wrQ[idx].bank : -1, bank);
    checkOutput($sformatf("addr[n=%0d]", n), (idx < wrQ.size()) ? wrQ[idx].addr : -1, addr);
    checkOutput($sformatf("data[n=%0d]", n), (idx < wrQ.size()) ? wrQ[idx].data : -1, n);
  endtask

  task automatic checkFrame(input bit named);
    int mism;
    mism = 0;
    checkOutput("writeCount", wrQ.size() - wrBase, expQ.size());
    for (int i = 0; i < expQ.size() && wrBase + i < wrQ.size(); i++) begin
      wr_t w;
      w = wrQ[wrBase + i];
      if (w.cyc != expQ[i].cyc || w.bank != expQ[i].bank || w.addr != expQ[i].addr ||
          w.data != expQ[i].data || w.weCnt != 1 || !w.addrSame) mism++;
    end
    checkOutput("writeContents", mism, 0);
    if (named) begin
`ifdef FHT_LOADER_DREV_EN
      checkNamed(0, 0, 0);
      checkNamed(1, 1, 0);
      checkNamed(4, 0, 64);
      checkNamed(1023, 3, 255);
`else
      checkNamed(1, 0, 1);
      checkNamed(256, 1, 0);
      checkNamed(1023, 3, 255);
`endif
    end
  endtask

  typedef struct {
    bit rst, arm, valid, acc;
    logic signed [D_BIT-2:0] smp;
    bit eReady, eBusy, eOvf, eWe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 0, 0, 0, 16'h0000, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 16'h0000, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 1, 0, 16'h1234, 0, 0, 1, 0};
    vecs[3] = '{0, 0, 0, 0, 16'h0000, 0, 0, 1, 0};
    vecs[4] = '{0, 1, 0, 0, 16'h0000, 1, 1, 0, 0};
    vecs[5] = '{0, 0, 1, 1, 16'h0000, 1, 1, 0, 1};
    vecs[6] = '{0, 0, 1, 1, 16'h0001, 1, 1, 0, 1};
    vecs[7] = '{0, 1, 1, 1, 16'h0002, 1, 1, 0, 1};
    vecs[8] = '{0, 0, 0, 0, 16'h0000, 1, 1, 0, 0};

    beginFrame();
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].acc) acceptSample(vecs[i].smp, vecs[i].arm, 1'b0);
      else applyStimulus(vecs[i].rst, vecs[i].arm, vecs[i].valid, vecs[i].smp, 1'b0);
      checkOutput($sformatf("vec%0d.ready", i), int'(oREADY), int'(vecs[i].eReady));
      checkOutput($sformatf("vec%0d.busy", i), int'(oBUSY), int'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d.ovf", i), int'(oOVF), int'(vecs[i].eOvf));
      checkOutput($sformatf("vec%0d.we", i), int'(oWE_0 | oWE_1 | oWE_2 | oWE_3), int'(vecs[i].eWe));
    end
    loadFrame(N - 3, 1'b0);
    finishFrame(2, 100);
    checkFrame(1'b1);

    for (int f = 0; f < 2; f++) begin
      startFrame();
      loadFrame(N, 1'b1);
      finishFrame($urandom_range(6), $urandom_range(20, 1));
      checkFrame(1'b0);
    end

    startFrame();
    loadFrame(500, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h7fff, 1'b1);
    checkOutput("rstFlags", int'({oREADY, oBUSY, oDONE, oSTART, oOVF, oWE_0, oWE_1, oWE_2, oWE_3}), 0);
    checkOutput("rstData", int'(oDATA), 0);
    checkOutput("rstAddr", int'(oADDR_WR_0 | oADDR_WR_1 | oADDR_WR_2 | oADDR_WR_3), 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'(i % 2));
    checkOutput("noStartAfterReset", startQ.size() - stBase, 0);
    checkOutput("noDoneAfterReset", doneQ.size() - dnBase, 0);
    checkFrame(1'b0);

    startFrame();
    loadFrame(N, 1'b0);
    finishFrame(2, 100);
    checkFrame(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
